// File: rtl/alu_seq_param_if.sv
// alu_seq_param_if -- request/response bundle for the alu_seq_param compute leaf.
//   master : controller side, drives start/opcode/A/B and observes the response.
//   slave  : ALU side, drives busy/done/error/Result (and flags when built with them).
// Optional feature macro: ALU_SEQ_FLAGS_EN adds the 4-bit {Z,C,V,N} flags signal.
interface alu_seq_param_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [2:0]             opcode;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [2*WIDTH-1:0]     Result;
`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0]             flags;

  modport master (output start, opcode, A, B,
                  input  busy, done, error, Result, flags);
  modport slave  (input  start, opcode, A, B,
                  output busy, done, error, Result, flags);
`else
  modport master (output start, opcode, A, B,
                  input  busy, done, error, Result);
  modport slave  (input  start, opcode, A, B,
                  output busy, done, error, Result);
`endif
endinterface

// File: rtl/alu_seq_param.sv
// alu_seq_param -- multi-cycle WIDTH-bit ALU with start/busy/done handshake.
//   clk    : clock, all state on posedge
//   reset  : asynchronous, active-high, clears all state
//   bus    : alu_seq_param_if.slave
//            start/opcode/A/B in; busy/done/error/Result (and flags) out
// ADD/SUB/AND/OR/XOR, reserved opcode and DIV-by-zero complete on the accept
// edge. MUL (shift-add) and DIV (restoring) iterate WIDTH edges in CALC, then
// publish the result from FIN one edge later.
// Optional feature macro: ALU_SEQ_FLAGS_EN -- registered {Z,C,V,N} flags.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  alu_seq_param_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  // Shared working register: {partial product, multiplier} or {remainder, quotient}.
  logic [2*WIDTH-1:0]   p_r, p_s;
  // Multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0]     opnd_r, opnd_s;
  logic                 is_div_r, is_div_s;
  logic [2*WIDTH-1:0]   result_r, result_s;
  logic                 done_r, done_s;
  logic                 busy_r, busy_s;
  logic                 error_r, error_s;

  logic [2*WIDTH-1:0]   a_ext_s, b_ext_s, add_s, sub_s;
  logic                 accept_s;

  // One shift-add step: add multiplicand to upper half when multiplier LSB is set, then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  // One restoring-divide step: shift next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff = sh[WIDTH-1:0] - d;
    if (sh >= {1'b0, d}) begin
      return {diff, p[WIDTH-2:0], 1'b1};
    end else begin
      return {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Zero-extended single-cycle arithmetic.
  always_comb begin
    a_ext_s  = {{WIDTH{1'b0}}, bus.A};
    b_ext_s  = {{WIDTH{1'b0}}, bus.B};
    add_s    = a_ext_s + b_ext_s;
    sub_s    = a_ext_s - b_ext_s;
    accept_s = bus.start & ~busy_r;
  end

  // Next-state and next-output logic for the IDLE/CALC/FIN sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    p_s      = p_r;
    opnd_s   = opnd_r;
    is_div_s = is_div_r;
    result_s = result_r;
    done_s   = 1'b0;
    busy_s   = busy_r;
    error_s  = error_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          error_s = 1'b0;
          done_s  = 1'b1;
          case (bus.opcode)
            OP_ADD: result_s = add_s;
            OP_SUB: result_s = sub_s;
            OP_AND: result_s = a_ext_s & b_ext_s;
            OP_OR:  result_s = a_ext_s | b_ext_s;
            OP_XOR: result_s = a_ext_s ^ b_ext_s;
            OP_MUL: begin
              done_s   = 1'b0;
              busy_s   = 1'b1;
              state_s  = ST_CALC;
              cnt_s    = CNT_W'(WIDTH);
              p_s      = {{WIDTH{1'b0}}, bus.B};
              opnd_s   = bus.A;
              is_div_s = 1'b0;
            end
            OP_DIV: begin
              if (bus.B == {WIDTH{1'b0}}) begin
                error_s  = 1'b1;
                result_s = {(2*WIDTH){1'b0}};
              end else begin
                done_s   = 1'b0;
                busy_s   = 1'b1;
                state_s  = ST_CALC;
                cnt_s    = CNT_W'(WIDTH);
                p_s      = {{WIDTH{1'b0}}, bus.A};
                opnd_s   = bus.B;
                is_div_s = 1'b1;
              end
            end
            default: begin
              error_s  = 1'b1;
              result_s = {(2*WIDTH){1'b0}};
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        p_s   = is_div_r ? div_step(p_r, opnd_r) : mul_step(p_r, opnd_r);
        cnt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIN: begin
        result_s = p_r;
        done_s   = 1'b1;
        busy_s   = 1'b0;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      p_r      <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      p_r      <= p_s;
      opnd_r   <= opnd_s;
      is_div_r <= is_div_s;
      result_r <= result_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
      error_r  <= error_s;
    end
  end

  assign bus.Result = result_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;
  assign bus.error  = error_r;

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_r, flags_s;
  logic [1:0] cv_s;

  // Carry/borrow and signed overflow exist only for single-cycle ADD/SUB.
  always_comb begin
    cv_s = 2'b00;
    if (state_r == ST_IDLE && bus.opcode == OP_ADD) begin
      cv_s = {add_s[WIDTH],
              (bus.A[WIDTH-1] ~^ bus.B[WIDTH-1]) & (add_s[WIDTH-1] ^ bus.A[WIDTH-1])};
    end else if (state_r == ST_IDLE && bus.opcode == OP_SUB) begin
      cv_s = {bus.A < bus.B,
              (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (sub_s[WIDTH-1] ^ bus.A[WIDTH-1])};
    end else begin
      cv_s = 2'b00;
    end
    if (done_s) begin
      flags_s = {result_s == {(2*WIDTH){1'b0}}, cv_s, result_s[WIDTH-1]};
    end else begin
      flags_s = flags_r;
    end
  end

  // Flags register, updated on the same edge as done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= flags_s;
    end
  end

  assign bus.flags = flags_r;
`endif

endmodule
